alu_mul_ctrl: RTL

ALU_MUL_CTRL -- requirements
Module: alu_mul_ctrl

---
 rtl/alu_mul_ctrl_if.sv | 33 +++
 rtl/alu_mul_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/alu_mul_ctrl_if.sv
// Bundle between the shift-add multiply sequencer and its requester/shared ALU.
// The requester (master) drives the operands and returns the combinational ALU result.
interface alu_mul_ctrl_if;
  logic        start;
  logic        sgn;
  logic [15:0] mcand;
  logic [15:0] mplier;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        ovf;
  logic [15:0] alu_A;
  logic [15:0] alu_B;
  logic        alu_Cin;
  logic        alu_invA;
  logic        alu_invB;
  logic        alu_sign;
  logic [2:0]  alu_Op;
  logic [15:0] alu_Out;
  logic        alu_Ofl;

  modport master (
    output start, sgn, mcand, mplier, alu_Out, alu_Ofl,
    input  busy, done, product, ovf,
    input  alu_A, alu_B, alu_Cin, alu_invA, alu_invB, alu_sign, alu_Op
  );

  modport slave (
    input  start, sgn, mcand, mplier, alu_Out, alu_Ofl,
    output busy, done, product, ovf,
    output alu_A, alu_B, alu_Cin, alu_invA, alu_invB, alu_sign, alu_Op
  );
endinterface

// File: rtl/alu_mul_ctrl.sv
// 16x16 shift-add multiply sequencer that borrows an external adder; signed mode
// multiplies magnitudes and negates the result at the end.
module alu_mul_ctrl (
  input  logic          clk,
  input  logic          rst,
  alu_mul_ctrl_if.slave bus
);
  localparam logic [2:0] OP_ADD = 3'b000;

  typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, RUN, FIX, DONE} state_t;

  state_t      state_q;
  logic [15:0] mcand_q, mplier_q, acc_q, product_q;
  logic        sgn_q, neg_a_q, neg_b_q, lost_q, ovf_acc_q;
  logic        ovf_q, done_q, busy_q;
  logic        neg_p;
  logic [15:0] alu_a, alu_b;
  logic        alu_inva, alu_cin;

  assign neg_p = neg_a_q ^ neg_b_q;

  // ALU operands are decoded from the current state so alu_Out can be captured this cycle.
  always_comb begin
    alu_a    = 16'd0;
    alu_b    = 16'd0;
    alu_inva = 1'b0;
    alu_cin  = 1'b0;
    case (state_q)
      ABS_A: begin
        alu_a    = mcand_q;
        alu_inva = mcand_q[15];
        alu_cin  = mcand_q[15];
      end
      ABS_B: begin
        alu_a    = mplier_q;
        alu_inva = mplier_q[15];
        alu_cin  = mplier_q[15];
      end
      RUN: begin
        if ((mplier_q != 16'd0) && mplier_q[0]) begin
          alu_a = acc_q;
          alu_b = mcand_q;
        end
      end
      FIX: begin
        alu_a    = acc_q;
        alu_inva = neg_p;
        alu_cin  = neg_p;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= 16'd0;
      mplier_q  <= 16'd0;
      acc_q     <= 16'd0;
      product_q <= 16'd0;
      sgn_q     <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      lost_q    <= 1'b0;
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            mcand_q   <= bus.mcand;
            mplier_q  <= bus.mplier;
            sgn_q     <= bus.sgn;
            acc_q     <= 16'd0;
            lost_q    <= 1'b0;
            ovf_acc_q <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= bus.sgn ? ABS_A : RUN;
          end
        end
        ABS_A: begin
          neg_a_q <= mcand_q[15];
          mcand_q <= bus.alu_Out;
          state_q <= ABS_B;
        end
        ABS_B: begin
          neg_b_q  <= mplier_q[15];
          mplier_q <= bus.alu_Out;
          state_q  <= RUN;
        end
        RUN: begin
          if (mplier_q == 16'd0) begin
            if (sgn_q) begin
              state_q <= FIX;
            end else begin
              product_q <= acc_q;
              ovf_q     <= ovf_acc_q;
              done_q    <= 1'b1;
              state_q   <= DONE;
            end
          end else begin
            // A set lost bit means the shifted multiplicand already exceeds 16 bits.
            if (mplier_q[0]) begin
              acc_q     <= bus.alu_Out;
              ovf_acc_q <= ovf_acc_q | bus.alu_Ofl | lost_q;
            end
            lost_q   <= lost_q | mcand_q[15];
            mplier_q <= mplier_q >> 1;
            mcand_q  <= mcand_q << 1;
          end
        end
        FIX: begin
          acc_q     <= bus.alu_Out;
          product_q <= bus.alu_Out;
          ovf_q     <= ovf_acc_q | (acc_q[15] & ~(neg_p & (acc_q == 16'h8000)));
          done_q    <= 1'b1;
          state_q   <= DONE;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.product  = product_q;
  assign bus.ovf      = ovf_q;
  assign bus.alu_A    = alu_a;
  assign bus.alu_B    = alu_b;
  assign bus.alu_Cin  = alu_cin;
  assign bus.alu_invA = alu_inva;
  assign bus.alu_invB = 1'b0;
  assign bus.alu_sign = 1'b0;
  assign bus.alu_Op   = OP_ADD;
endmodule
